// File: rtl/ram_tx_serializer.sv
// Streams a block of bytes from the TX buffer RAM onto an async serial line.
// Frame: start bit (0), DATA_WIDTH bits LSB first, stop bit (1).
module ram_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 2,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0]       CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]       BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         clk_q, clk_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH:0]   len_sat;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  clk_last;

    assign len_sat  = (length > DEPTH) ? DEPTH : length;
    assign cnt_inc  = cnt_q + 1'b1;
    assign clk_last = (clk_q == CLK_LAST);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        clk_d   = clk_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            // DONE also accepts start so a new transfer can begin right after the pulse
            S_IDLE, S_DONE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    len_d = len_sat;
                    cnt_d = '0;
                    clk_d = '0;
                    bit_d = '0;
                    if (len_sat == '0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = '0;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = ram_q;
                tx_d    = 1'b0;
                clk_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (clk_last) begin
                    clk_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_last) begin
                    clk_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_last) begin
                    clk_d = '0;
                    cnt_d = cnt_inc;
                    if (cnt_inc < len_q) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            clk_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            clk_q   <= clk_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram_addr = addr_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/ram_tx_serializer.md
# ram_tx_serializer

Reads a block of bytes out of the single-port TX buffer RAM and transmits them as asynchronous serial frames: one start bit, DATA_WIDTH data bits LSB first, one stop bit. It sits directly downstream of the TX buffer RAM. It drives that RAM's address port and consumes its q output. The RAM registers the address on the rising clock edge, so q is valid one cycle after the address is presented. The serial line out of this block is the TX pin of the link.

## Interface

- DATA_WIDTH, 8: width of each RAM word and of the serial payload.
- ADDR_WIDTH, 2: RAM address width; buffer depth is 2**ADDR_WIDTH.
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal values are 2 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request to transmit; sampled only in IDLE.
- length  in  ADDR_WIDTH+1  number of bytes to send, starting at address 0; sampled with start.
- ram_addr  out  ADDR_WIDTH  registered read address to the RAM.
- ram_q  in  DATA_WIDTH  RAM read data, valid one cycle after ram_addr.
- tx  out  1  serial line; idles high.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of a transfer.

## Operation

- States are IDLE, FETCH, LOAD, START, DATA, STOP, DONE.
- Reset values: tx=1, busy=0, done=0, ram_addr=0, state IDLE, all counters 0.
- IDLE: tx=1. When start=1, latch length, saturated to 2**ADDR_WIDTH.
  - If the latched length is 0, go to DONE; no frame is sent.
  - Otherwise set ram_addr=0, set busy=1, and go to FETCH.
- FETCH: wait one cycle for the RAM to register the address; tx=1. Go to LOAD.
- LOAD: ram_q is valid. Capture it into the shift register. Set tx=0 and go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles. Then put bit 0 on tx and go to DATA.
- DATA: each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After DATA_WIDTH bits, set tx=1 and go to STOP.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. Then increment the byte counter.
  - If bytes remain, ram_addr <= ram_addr+1 and go to FETCH.
  - Otherwise go to DONE.
- DONE: done=1 for exactly one cycle; busy drops in the same cycle. Return to IDLE.
- start while busy=1 is ignored; length changes during a transfer have no effect.
- ram_addr wraps modulo 2**ADDR_WIDTH. It never exceeds length-1 within a transfer and holds its last value after the transfer.
- rst asserted at any time forces tx=1, busy=0, done=0 and IDLE immediately. No partial frame is resumed.
- The block never asserts a RAM write; the write side belongs to the producer. If the producer writes a word after its LOAD cycle, the frame already being sent still carries the old value.

## Timing

- Let T0 be the edge that accepts start (start=1 in IDLE).
  - Edge T0: ram_addr=0 and busy=1.
  - Edge T1: state LOAD.
  - Edge T2: tx falls (start bit).
- One frame lasts (DATA_WIDTH+2)*CLKS_PER_BIT cycles of tx activity.
- There are 2 idle-high cycles (FETCH, LOAD) between consecutive frames.
- For N≥1 bytes, done is high in the cycle starting at edge T0 + N*(2+(DATA_WIDTH+2)*CLKS_PER_BIT). busy is low from that same edge.
- For N=0, done pulses in the cycle after T0 and tx never leaves 1.
- The earliest new start is accepted on the edge after the done cycle.

## Test plan

Benches use CLKS_PER_BIT=4 and DATA_WIDTH=8 (42 cycles per byte).

- Reset check: assert rst mid-run, then release it -> tx=1, busy=0, done=0, ram_addr=0. A later start=1 with length=1 sends exactly one frame.
- Single byte: RAM[0]=0xA5, length=1 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses once at T0+42; busy is high T0..T0+41.
- Full buffer: RAM = 0x01,0x80,0xFF,0x00, length=4 -> four frames decode in address order. There are 2 idle-high cycles between frames, done at T0+168, and ram_addr ends at 3.
- Saturation and zero length: length=7 sends exactly 4 frames. length=0 -> done in the cycle after T0, with no tx low at any point.
- Busy collisions: pulse start during frame 2 of a 4-byte transfer -> ignored, with exactly 4 frames and 1 done pulse. Rewrite RAM[3] via the write port before its FETCH -> the new value is transmitted.
- Reset mid-frame: assert rst during DATA of byte 1 -> tx=1 asynchronously, before the next edge. After release the block is in IDLE, and a fresh length=1 transfer sends RAM[0].
